// File: rtl/mlp_chain_seq.sv
// mlp_chain_seq: start/busy/drain sequencer for a chain of fc_layer stages.
// Define CHAIN_PERF_CNT_EN to add the o_frame_cycles latency output.
module mlp_chain_seq #(
  parameter int NUM_LAYERS = 5,
  parameter int datatype_size = 2,
  parameter int MAX_SIZE = 1500,
  parameter logic [16*NUM_LAYERS-1:0] OUT_SIZES =
    {16'd10, 16'd500, 16'd1000, 16'd1500, 16'd784},
  localparam int AW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1,
  localparam int N = NUM_LAYERS,
  localparam int DW = datatype_size
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  output logic            o_ready,
  output logic [N-1:0]    o_start,
  input  logic [N-1:0]    i_busy,
  input  logic [N-1:0]    i_func_valid,
  input  logic [N*DW-1:0] i_func_data,
  output logic [N-1:0]    o_func_ready,
  output logic [N-1:0]    o_ibuf_we,
  output logic [N*DW-1:0] o_ibuf_wr_data,
  output logic [N*AW-1:0] o_ibuf_addr,
  output logic            o_out_valid,
  output logic [DW-1:0]   o_out_data,
  output logic            o_frame_done,
  output logic            o_overflow
`ifdef CHAIN_PERF_CNT_EN
  ,
  output logic [31:0]     o_frame_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_RUN, S_DRAIN
  } state_e;

  state_e        st_q  [N];
  logic [AW-1:0] cnt_q [N];
  logic [N-1:0]  busy_q;

  logic [N-1:0]  idle, drain, waitb;
  logic [N-1:0]  fire, last, go;
  logic          ovf_d;

  function automatic logic [15:0] last_idx(int k);
    return OUT_SIZES[16*k +: 16] - 16'd1;
  endfunction

  assign o_ready = idle[0];

  // Stage decode, downstream backpressure and protocol-error detect
  always_comb begin
    idle = '0;
    drain = '0;
    waitb = '0;
    o_start = '0;
    o_func_ready = '0;
    last = '0;
    go = '0;
    for (int k = 0; k < N; k++) begin
      idle[k]    = (st_q[k] == S_IDLE);
      drain[k]   = (st_q[k] == S_DRAIN);
      waitb[k]   = (st_q[k] == S_WAIT);
      o_start[k] = (st_q[k] == S_LAUNCH);
    end
    for (int k = 0; k < N; k++) begin
      o_func_ready[k] = drain[k] &
        ((k == N - 1) ? 1'b1 : idle[(k + 1) % N]);
    end
    fire = i_func_valid & o_func_ready;
    for (int k = 0; k < N; k++) begin
      last[k] = fire[k] && (16'(cnt_q[k]) == last_idx(k));
      go[k] = (k == 0) ? (i_start & idle[0])
                       : last[(k + N - 1) % N];
    end
    ovf_d = (|(i_func_valid & ~drain)) |
            (|(busy_q & ~i_busy & waitb));
  end

  // Per-stage FSMs, counters and registered write/out paths
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        st_q[k]  <= S_IDLE;
        cnt_q[k] <= '0;
      end
      busy_q         <= '0;
      o_overflow     <= 1'b0;
      o_ibuf_we      <= '0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr    <= '0;
      o_out_valid    <= 1'b0;
      o_out_data     <= '0;
      o_frame_done   <= 1'b0;
    end else begin
      busy_q <= i_busy;
      if (ovf_d) o_overflow <= 1'b1;
      for (int k = 0; k < N; k++) begin
        unique case (st_q[k])
          S_IDLE:   if (go[k]) st_q[k] <= S_LAUNCH;
          S_LAUNCH: st_q[k] <= S_WAIT;
          S_WAIT:   if (i_busy[k]) st_q[k] <= S_RUN;
          S_RUN:    if (!i_busy[k]) st_q[k] <= S_DRAIN;
          S_DRAIN: begin
            if (fire[k]) begin
              if (last[k]) begin
                st_q[k]  <= S_IDLE;
                cnt_q[k] <= '0;
              end else begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
              end
            end
          end
          default:  st_q[k] <= S_IDLE;
        endcase
      end
      o_ibuf_we <= fire << 1;
      for (int k = 0; k < N - 1; k++) begin
        if (fire[k]) begin
          o_ibuf_wr_data[(k+1)*DW +: DW] <=
            i_func_data[k*DW +: DW];
          o_ibuf_addr[(k+1)*AW +: AW] <= cnt_q[k];
        end
      end
      o_out_valid <= fire[N-1];
      if (fire[N-1])
        o_out_data <= i_func_data[(N-1)*DW +: DW];
      o_frame_done <= last[N-1];
    end
  end

`ifdef CHAIN_PERF_CNT_EN
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [31:0]   fcnt_q;
  logic [31:0]   cap_q [N];
  logic [PW-1:0] wp_q, rp_q;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  // Start-time capture FIFO; latency reported with frame done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      o_frame_cycles <= '0;
      for (int k = 0; k < N; k++) cap_q[k] <= '0;
    end else begin
      fcnt_q <= fcnt_q + 32'd1;
      if (go[0]) begin
        cap_q[wp_q] <= fcnt_q;
        wp_q <= nxt(wp_q);
      end
      if (last[N-1]) begin
        o_frame_cycles <= fcnt_q - cap_q[rp_q];
        rp_q <= nxt(rp_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mlp_chain_seq.sv
// tb_mlp_chain_seq: directed bench, 2-layer chain (4 then 3 words).
// Scoreboard queues hold expected ibuf writes and output words.
module tb_mlp_chain_seq;

  localparam int N = 2;
  localparam int DW = 2;
  localparam int MS = 1500;
  localparam int AW = 11;
  localparam logic [31:0] OS = {16'd3, 16'd4};
  localparam int SZ0 = 4;
  localparam int SZ1 = 3;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic o_ready;
  logic [N-1:0] o_start, i_busy, i_func_valid, o_func_ready, o_ibuf_we;
  logic [N*DW-1:0] i_func_data, o_ibuf_wr_data;
  logic [N*AW-1:0] o_ibuf_addr;
  logic o_out_valid;
  logic [DW-1:0] o_out_data;
  logic o_frame_done, o_overflow;

  logic b0, b1, v0, v1;
  logic [1:0] d0, d1;
  assign i_busy = {b1, b0};
  assign i_func_valid = {v1, v0};
  assign i_func_data = {d1, d0};

  mlp_chain_seq #(
    .NUM_LAYERS(N), .datatype_size(DW),
    .MAX_SIZE(MS), .OUT_SIZES(OS)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_ready(o_ready),
    .o_start(o_start), .i_busy(i_busy),
    .i_func_valid(i_func_valid), .i_func_data(i_func_data),
    .o_func_ready(o_func_ready), .o_ibuf_we(o_ibuf_we),
    .o_ibuf_wr_data(o_ibuf_wr_data), .o_ibuf_addr(o_ibuf_addr),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data),
    .o_frame_done(o_frame_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  d;
    logic [10:0] a;
  } wr_t;
  typedef struct packed {
    logic [1:0] d;
    logic       last;
  } out_t;

  wr_t  wq[$];
  out_t oq[$];
  wr_t  we_exp;
  out_t oe_exp;
  int   cm0, cm1;
  int   addr_log[$];
  int   outs_seen, done_seen, done_idx;
  bit   fb_drain;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: condition false", nm);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    outs_seen = 0;
    done_seen = 0;
    done_idx = 0;
  endtask

  // Model: layer k words arrive in order, addressed by position in frame
  task automatic push(input int k, input logic [1:0] w);
    if (k == 0) begin
      wq.push_back('{d: w, a: 11'(cm0)});
      cm0++;
      if (cm0 == SZ0) cm0 = 0;
    end else begin
      oq.push_back('{d: w, last: (cm1 == SZ1 - 1)});
      cm1++;
      if (cm1 == SZ1) cm1 = 0;
    end
  endtask

  task automatic setv(input int k, input logic v, input logic [1:0] d);
    if (k == 0) begin v0 = v; d0 = d; end
    else begin v1 = v; d1 = d; end
  endtask

  task automatic setb(input int k, input logic b);
    if (k == 0) b0 = b;
    else b1 = b;
  endtask

  task automatic start_frame();
    bit ok;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (o_ready) ok = 1;
      else @(negedge clk);
    end
    flag("ready_for_start", ok);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("launch0", 32'(o_start[0]), 1);
  endtask

  task automatic layer_busy(input int k, input int n);
    bit seen;
    seen = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      if (o_start[k]) seen = 1;
      else @(negedge clk);
    end
    flag($sformatf("launch_seen%0d", k), seen);
    if (seen) begin
      setb(k, 1'b1);
      @(negedge clk);
      chk("start_len", 32'(o_start[k]), 0);
      repeat (n - 1) @(negedge clk);
      setb(k, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic send_words(input int k, input int n, input int base);
    bit ok;
    logic [1:0] w;
    for (int i = 0; i < n; i++) begin
      ok = 0;
      w = 2'(base + i);
      setv(k, 1'b1, w);
      for (int t = 0; t < 300 && !ok; t++) begin
        if (o_func_ready[k]) begin
          ok = 1;
          push(k, w);
        end
        @(negedge clk);
      end
      setv(k, 1'b0, 2'b00);
      flag("ready_wait", ok);
    end
  endtask

  task automatic run_frame(input int base0, input int base1);
    fork
      begin
        start_frame();
        layer_busy(0, 5);
        send_words(0, SZ0, base0);
      end
      begin
        layer_busy(1, 5);
        send_words(1, SZ1, base1);
      end
    join
  endtask

  task automatic check_addrs(input int n);
    chk("addr_count", 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < addr_log.size() && i < n; i++)
      chk($sformatf("addr_%0d", i), 32'(addr_log[i]), 32'(i % 4));
  endtask

  // Compare process: every visible write/output word against the model
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("slot0_tied", 32'({o_ibuf_we[0], o_ibuf_wr_data[1:0],
                             o_ibuf_addr[10:0]}), 0);
      if (o_ibuf_we[1]) begin
        flag("wr_expected", wq.size() > 0);
        if (wq.size() > 0) begin
          we_exp = wq.pop_front();
          chk("wr_data", 32'(o_ibuf_wr_data[3:2]), 32'(we_exp.d));
          chk("wr_addr", 32'(o_ibuf_addr[21:11]), 32'(we_exp.a));
          addr_log.push_back(int'(o_ibuf_addr[21:11]));
        end
      end
      if (o_out_valid) begin
        flag("out_expected", oq.size() > 0);
        outs_seen++;
        if (o_frame_done) begin
          done_seen++;
          done_idx = outs_seen;
        end
        if (oq.size() > 0) begin
          oe_exp = oq.pop_front();
          chk("out_data", 32'(o_out_data), 32'(oe_exp.d));
          chk("frame_done", 32'(o_frame_done), 32'(oe_exp.last));
        end
      end else begin
        chk("done_wo_valid", 32'(o_frame_done), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    i_start = 1'b0;
    b0 = 0; b1 = 0; v0 = 0; v1 = 0; d0 = 0; d1 = 0;
    cm0 = 0; cm1 = 0; fb_drain = 0;
    clear_logs();

    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_start", 32'(o_start), 0);
    chk("rst_fready", 32'(o_func_ready), 0);
    chk("rst_outs", 32'({o_out_valid, o_frame_done, o_overflow}), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame: 4 writes at 0..3, 3 output words, done on third
    clear_logs();
    run_frame(0, 1);
    repeat (3) @(negedge clk);
    check_addrs(4);
    chk("t1_outs", 32'(outs_seen), 3);
    chk("t1_dones", 32'(done_seen), 1);
    chk("t1_done_idx", 32'(done_idx), 3);
    chk("t1_ovf", 32'(o_overflow), 0);
    flag("t1_q_empty", wq.size() == 0 && oq.size() == 0);

    // Backpressure from stage 1 held in RUN, ignored/accepted starts
    clear_logs();
    fb_drain = 0;
    fork
      begin
        start_frame();
        fork
          layer_busy(0, 5);
          begin
            repeat (2) @(negedge clk);
            i_start = 1'b1;
            chk("ready_low", 32'(o_ready), 0);
            @(negedge clk);
            i_start = 1'b0;
            chk("start_ignored", 32'(o_start[0]), 0);
          end
        join
        send_words(0, SZ0, 0);
        start_frame();
        chk("l1_not_drain", 32'(o_func_ready[1]), 0);
        layer_busy(0, 5);
        fb_drain = 1;
        send_words(0, SZ0, 3);
      end
      begin
        layer_busy(1, 40);
        send_words(1, SZ1, 1);
        layer_busy(1, 5);
        send_words(1, SZ1, 2);
      end
      begin
        for (int t = 0; t < 300 && !fb_drain; t++) @(negedge clk);
        flag("fb_drain_reached", fb_drain);
        for (int i = 0; i < 8; i++) begin
          chk("hold_ready0", 32'(o_func_ready[0]), 0);
          chk("hold_no_wr", 32'(o_ibuf_we[1]), 0);
          @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);
    check_addrs(8);
    chk("t2_outs", 32'(outs_seen), 6);
    chk("t2_dones", 32'(done_seen), 2);
    chk("t2_ovf", 32'(o_overflow), 0);
    flag("t2_q_empty", wq.size() == 0 && oq.size() == 0);

    // Word offered to an idle stage: sticky overflow, dropped
    clear_logs();
    setv(0, 1'b1, 2'b11);
    @(negedge clk);
    setv(0, 1'b0, 2'b00);
    chk("ovf_set", 32'(o_overflow), 1);
    chk("ovf_no_wr", 32'(o_ibuf_we[1]), 0);
    @(negedge clk);
    chk("ovf_sticky", 32'(o_overflow), 1);
    run_frame(2, 0);
    repeat (3) @(negedge clk);
    check_addrs(4);
    chk("t3_outs", 32'(outs_seen), 3);
    chk("t3_dones", 32'(done_seen), 1);
    chk("t3_ovf_hold", 32'(o_overflow), 1);

    // Reset mid-frame after 2 of 4 transfers
    clear_logs();
    start_frame();
    layer_busy(0, 5);
    send_words(0, 2, 1);
    @(negedge clk);
    chk("pre_rst_wr", 32'(addr_log.size()), 2);
    rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(o_ready), 1);
    chk("mrst_start", 32'(o_start), 0);
    chk("mrst_fready", 32'(o_func_ready), 0);
    chk("mrst_we", 32'(o_ibuf_we), 0);
    chk("mrst_wdata", 32'(o_ibuf_wr_data), 0);
    chk("mrst_addr", 32'(o_ibuf_addr), 0);
    chk("mrst_out", 32'({o_out_valid, o_out_data}), 0);
    chk("mrst_flags", 32'({o_frame_done, o_overflow}), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_done", 32'(o_frame_done), 0);
    end
    wq.delete();
    oq.delete();
    cm0 = 0;
    cm1 = 0;
    rst = 1'b1;
    @(negedge clk);
    clear_logs();
    run_frame(1, 2);
    repeat (3) @(negedge clk);
    check_addrs(4);
    chk("t4_outs", 32'(outs_seen), 3);
    chk("t4_dones", 32'(done_seen), 1);
    chk("t4_ovf", 32'(o_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mlp_chain_seq.md
MLP_CHAIN_SEQ -- requirements
Module: mlp_chain_seq

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 5: number of chained fc_layer stages (1..8).
REQ-002 SHALL have parameter datatype_size, default 2: bits per activation word.
REQ-003 SHALL have parameter MAX_SIZE, default 1500: largest layer output count; AW = $clog2(MAX_SIZE).
REQ-004 SHALL have parameter OUT_SIZES, default {16'd10,16'd500,16'd1000,16'd1500,16'd784}: packed 16 bits per layer, layer k in bits [16k+15:16k], each value 1..MAX_SIZE.
REQ-005 SHALL have ports, in this order:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_start  input  1  frame start pulse.
- o_ready  output  1  stage 0 idle; i_start is accepted.
- o_start  output  NUM_LAYERS  per-layer start pulse.
- i_busy  input  NUM_LAYERS  per-layer busy.
- i_func_valid  input  NUM_LAYERS  per-layer output word valid.
- i_func_data  input  NUM_LAYERS*datatype_size  per-layer output word, layer k at [k*datatype_size +: datatype_size].
- o_func_ready  output  NUM_LAYERS  word accepted this cycle.
- o_ibuf_we  output  NUM_LAYERS  input-buffer write enable; bit 0 tied 0.
- o_ibuf_wr_data  output  NUM_LAYERS*datatype_size  input-buffer write data.
- o_ibuf_addr  output  NUM_LAYERS*AW  input-buffer write address.
- o_out_valid  output  1  final-layer word valid.
- o_out_data  output  datatype_size  final-layer word.
- o_frame_done  output  1  one-cycle pulse when the last word of the last layer is emitted.
- o_overflow  output  1  sticky protocol-error flag.

Function
REQ-006 SHALL run one FSM per stage k with states IDLE, LAUNCH, WAIT_BUSY, RUN, DRAIN.
REQ-007 Stage 0 SHALL leave IDLE on i_start while o_ready=1; i_start at any other time SHALL be ignored.
REQ-008 Stage k>0 SHALL leave IDLE in the cycle after stage k-1 completes DRAIN.
REQ-009 LAUNCH SHALL last exactly one cycle, with o_start[k]=1, then go to WAIT_BUSY.
REQ-010 WAIT_BUSY SHALL go to RUN when i_busy[k]=1; RUN SHALL go to DRAIN when i_busy[k]=0.
REQ-011 In DRAIN, o_func_ready[k] SHALL equal 1 only when k=NUM_LAYERS-1 or stage k+1 is in IDLE; this is the downstream input-buffer-free backpressure.
REQ-012 A transfer SHALL occur when i_func_valid[k] and o_func_ready[k] are both 1.
REQ-013 For k<NUM_LAYERS-1, each transfer SHALL register the following one cycle later: o_ibuf_we[k+1]=1, o_ibuf_wr_data[k+1]=word, o_ibuf_addr[k+1]=count.
REQ-014 For k=NUM_LAYERS-1, each transfer SHALL register o_out_valid=1 and o_out_data=word one cycle later.
REQ-015 The per-stage count SHALL start at 0 and increment per transfer; the transfer at count=OUT_SIZES[k]-1 SHALL return the stage to IDLE and clear count.
REQ-016 For the last stage, that final transfer SHALL also pulse o_frame_done aligned with the last o_out_valid.
REQ-017 Pipelining: stage 0 SHALL accept a new frame while later stages still process earlier frames.
REQ-018 o_overflow SHALL set on any of the following and hold until reset:
- i_func_valid[k]=1 while stage k is not in DRAIN;
- i_busy[k] falling while stage k is in WAIT_BUSY.
REQ-019 Words rejected under REQ-018 SHALL be dropped with no write and no count change.
REQ-020 NUM_LAYERS=1 SHALL give stage 0 writing directly to the o_out path.

Reset
REQ-021 rst=0 SHALL asynchronously force:
- all FSMs to IDLE and all counts to 0;
- all outputs to 0 except o_ready=1.
REQ-022 Reset asserted mid-frame SHALL discard the frame; no o_frame_done SHALL follow.
REQ-023 After reset deasserts, the first accepted i_start SHALL be one sampled at least one clk edge later.

Configuration
REQ-024 With CHAIN_PERF_CNT_EN defined, the module SHALL add output o_frame_cycles, 32 bits:
- a free-running counter is captured on each i_start acceptance;
- on o_frame_done, o_frame_cycles = current counter minus the oldest in-flight capture, via a NUM_LAYERS-deep capture FIFO;
- o_frame_cycles resets to 0.
REQ-025 Without CHAIN_PERF_CNT_EN, the port, counter and FIFO SHALL be absent.

Verification
REQ-026 NUM_LAYERS=2, OUT_SIZES={16'd3,16'd4}:
- stimulus: i_start; busy pulses 5 cycles per layer; 4 layer-0 words, then 3 layer-1 words;
- required: o_ibuf_addr[1] = 0,1,2,3; 3 o_out_valid; o_frame_done on the 3rd word.
REQ-027 Stage 1 held in RUN while stage 0 DRAINs:
- required: o_func_ready[0]=0 and no o_ibuf_we[1] until stage 1 returns to IDLE, then 4 writes complete.
REQ-028 i_func_valid[0]=1 while stage 0 is in IDLE:
- required: o_overflow=1, no write, count stays 0.
REQ-029 i_start while o_ready=0:
- required: no o_start[0] pulse.
- second i_start after stage 0 finishes DRAIN: o_start[0] pulses while stage 1 is still in RUN.
REQ-030 Reset pulled low after 2 of 4 transfers:
- required: all outputs 0, o_ready=1, no o_frame_done;
- a new frame then completes with addresses starting at 0.
